// File: rtl/regfile_read_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// lc3_rf_pkg
// Shared definitions for the SR2 register-file read-port arbiter.
//   arb_state_t     : arbiter FSM state (ARB = round-robin, LOCKED = one owner)
//   LC3_REG_ADDR_W  : register index width of the LC-3 register file
//   LC3_DATA_W      : register width
//   LC3_MAX_REQ     : upper bound on the requester count
//   onehot()        : index to one-hot vector of LC3_MAX_REQ bits
// ---------------------------------------------------------------------------
package lc3_rf_pkg;

    localparam int LC3_REG_ADDR_W = 3;
    localparam int LC3_DATA_W     = 16;
    localparam int LC3_MAX_REQ    = 8;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    function automatic logic [LC3_MAX_REQ-1:0] onehot(input logic [2:0] idx);
        logic [LC3_MAX_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/regfile_read_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_read_arbiter_if
// Bundles the requester handshake, the register-file mux select/data and the
// response bus.
//   master : requesters plus register file (drive req_*, rd_data)
//   slave  : the arbiter (drives req_ready, sel, rsp_*)
// Requester i's register index sits at req_addr[i*ADDR_W +: ADDR_W].
// ---------------------------------------------------------------------------
interface regfile_read_arbiter_if
    import lc3_rf_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = LC3_DATA_W,
    parameter int ADDR_W  = LC3_REG_ADDR_W
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic [ADDR_W-1:0]         sel;
    logic [DATA_W-1:0]         rd_data;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;

    modport master (
        output req_valid, req_lock, req_addr, rd_data,
        input  req_ready, sel, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_lock, req_addr, rd_data,
        output req_ready, sel, rsp_valid, rsp_data
    );

endinterface

// File: rtl/regfile_read_arbiter_rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Combinational round-robin picker: finds the first set bit of req searching
// upward from start and wrapping from N-1 to 0.
//   req   in  N     request vector
//   start in  IW    highest-priority index (must be < N)
//   valid out 1     at least one request present
//   idx   out IW    chosen index (0 when !valid)
//   grant out N     one-hot of idx, zero when !valid
// ---------------------------------------------------------------------------
module rr_priority_pick #(
    parameter  int N  = 3,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          valid,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  grant
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        grant = '0;
        sum   = '0;
        cand  = '0;
        // Walk offsets from farthest to nearest so the nearest hit wins.
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, start} + (IW + 1)'(k);
            if (sum >= (IW + 1)'(N)) begin
                sum = sum - (IW + 1)'(N);
            end
            cand = sum[IW-1:0];
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
        if (valid) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_read_arbiter
// Shares the single SR2 register-file read port between NUM_REQ requesters.
// Round-robin grant in ARB; a requester that asserts req_lock with its grant
// keeps the port (LOCKED) until it issues an unlocked beat or stays idle for
// LOCK_MAX cycles. The grant drives sel combinationally; rd_data is captured
// and returned one cycle later on rsp_valid/rsp_data.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of regfile_read_arbiter_if
// ---------------------------------------------------------------------------
module regfile_read_arbiter
    import lc3_rf_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int DATA_W   = LC3_DATA_W,
    parameter int ADDR_W   = LC3_REG_ADDR_W,
    parameter int LOCK_MAX = 15
) (
    input logic                  clk,
    input logic                  rst_n,
    regfile_read_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [7:0]         idle_cnt;
    logic [ADDR_W-1:0]  last_sel;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [DATA_W-1:0]  rsp_data_q;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_grant;

    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant_vec;
    logic [ADDR_W-1:0]  grant_addr;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    rr_priority_pick #(.N(NUM_REQ)) u_pick (
        .req   (bus.req_valid),
        .start (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx),
        .grant (pick_grant)
    );

    // In LOCKED only the owner's own request can produce a grant.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_vec   = '0;
        if (state == ARB) begin
            grant_valid = pick_valid;
            grant_idx   = pick_idx;
            grant_vec   = pick_grant;
        end else begin
            grant_valid = bus.req_valid[owner];
            grant_idx   = owner;
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_vec[i] = (IDX_W'(i) == owner) && bus.req_valid[i];
            end
        end
        grant_addr = bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
    end

    assign bus.req_ready = grant_vec;
    assign bus.sel       = grant_valid ? grant_addr : last_sel;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB;
            rr_ptr      <= '0;
            owner       <= '0;
            idle_cnt    <= '0;
            last_sel    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= grant_vec;
            if (grant_valid) begin
                rsp_data_q <= bus.rd_data;
                last_sel   <= grant_addr;
            end

            case (state)
                ARB: begin
                    if (grant_valid) begin
                        rr_ptr <= next_idx(grant_idx);
                        if (bus.req_lock[grant_idx]) begin
                            state    <= LOCKED;
                            owner    <= grant_idx;
                            idle_cnt <= '0;
                        end
                    end
                end
                LOCKED: begin
                    if (grant_valid) begin
                        if (bus.req_lock[owner]) begin
                            idle_cnt <= '0;
                        end else begin
                            state  <= ARB;
                            rr_ptr <= next_idx(owner);
                        end
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                        // This idle cycle is the LOCK_MAX-th: force release.
                        if (idle_cnt == 8'(LOCK_MAX - 1)) begin
                            state  <= ARB;
                            rr_ptr <= next_idx(owner);
                        end
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_read_arbiter
// Directed bench for regfile_read_arbiter (NUM_REQ=3, LOCK_MAX=15). Inputs
// change on the falling edge; combinational outputs are sampled 1 ns later,
// registered responses 1 ns after the rising edge. The register file is a
// fixed table behind sel.
// ---------------------------------------------------------------------------
module tb_regfile_read_arbiter;
    import lc3_rf_pkg::*;

    localparam int NUM_REQ  = 3;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int LOCK_MAX = 15;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [DATA_W-1:0] regs [8];

    regfile_read_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_read_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    assign bus.rd_data = regs[bus.sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [2:0] v, input logic [2:0] l,
                         input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2);
        @(negedge clk);
        bus.req_valid = v;
        bus.req_lock  = l;
        bus.req_addr  = {a2, a1, a0};
        #1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.req_ready !== 3'b000) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 000", bus.req_ready);
        end
        checks++;
        if (bus.sel !== 3'd0) begin
            failures++;
            $display("FAIL reset_sel: got %0d expected 0", bus.sel);
        end
        checks++;
        if (bus.rsp_valid !== 3'b000 || bus.rsp_data !== 16'h0000) begin
            failures++;
            $display("FAIL reset_rsp: got valid=%b data=%h expected 000/0000",
                     bus.rsp_valid, bus.rsp_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        int exp_g [4] = '{0, 1, 2, 0};
        int exp_a [4] = '{1, 4, 7, 1};
        logic [2:0] oh;
        for (int b = 0; b < 4; b++) begin
            drive(3'b111, 3'b000, 3'd1, 3'd4, 3'd7);
            oh = 3'(onehot(3'(exp_g[b])));
            checks++;
            if (bus.req_ready !== oh || bus.sel !== 3'(exp_a[b])) begin
                failures++;
                $display("FAIL rr_grant[%0d]: got ready=%b sel=%0d expected ready=%b sel=%0d",
                         b, bus.req_ready, bus.sel, oh, exp_a[b]);
            end
            after_edge();
            checks++;
            if (bus.rsp_valid !== oh || bus.rsp_data !== regs[exp_a[b]]) begin
                failures++;
                $display("FAIL rr_rsp[%0d]: got valid=%b data=%h expected valid=%b data=%h",
                         b, bus.rsp_valid, bus.rsp_data, oh, regs[exp_a[b]]);
            end
        end
    endtask

    // rr_ptr is 1 here, so requester 1 wins the first locked beat.
    task automatic test_lock_dump();
        for (int b = 0; b < 8; b++) begin
            drive(3'b111, (b < 7) ? 3'b010 : 3'b000, 3'd3, 3'(b), 3'd6);
            checks++;
            if (bus.req_ready !== 3'b010 || bus.sel !== 3'(b)) begin
                failures++;
                $display("FAIL lock_grant[%0d]: got ready=%b sel=%0d expected ready=010 sel=%0d",
                         b, bus.req_ready, bus.sel, b);
            end
            after_edge();
            checks++;
            if (bus.rsp_valid !== 3'b010 || bus.rsp_data !== regs[b]) begin
                failures++;
                $display("FAIL lock_rsp[%0d]: got valid=%b data=%h expected valid=010 data=%h",
                         b, bus.rsp_valid, bus.rsp_data, regs[b]);
            end
        end
        drive(3'b101, 3'b000, 3'd3, 3'd0, 3'd6);
        checks++;
        if (bus.req_ready !== 3'b100 || bus.sel !== 3'd6) begin
            failures++;
            $display("FAIL lock_after_release: got ready=%b sel=%0d expected ready=100 sel=6",
                     bus.req_ready, bus.sel);
        end
        after_edge();
    endtask

    // rr_ptr is 0 here; requester 1 takes the lock, then goes silent.
    task automatic test_forced_release();
        int early;
        drive(3'b010, 3'b010, 3'd0, 3'd2, 3'd0);
        checks++;
        if (bus.req_ready !== 3'b010) begin
            failures++;
            $display("FAIL idle_lock_grant: got ready=%b expected 010", bus.req_ready);
        end
        after_edge();
        early = 0;
        for (int c = 1; c <= LOCK_MAX; c++) begin
            drive(3'b101, 3'b000, 3'd3, 3'd2, 3'd5);
            if (bus.req_ready !== 3'b000) early++;
            after_edge();
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL idle_hold: got %0d grants during idle window expected 0", early);
        end
        drive(3'b101, 3'b000, 3'd3, 3'd2, 3'd5);
        checks++;
        if (bus.req_ready !== 3'b100 || bus.sel !== 3'd5) begin
            failures++;
            $display("FAIL idle_release: got ready=%b sel=%0d expected ready=100 sel=5",
                     bus.req_ready, bus.sel);
        end
        after_edge();
    endtask

    // rr_ptr is 0 here; only requester 1 asks, once.
    task automatic test_single();
        drive(3'b010, 3'b000, 3'd0, 3'd5, 3'd0);
        checks++;
        if (bus.req_ready !== 3'b010 || bus.sel !== 3'd5) begin
            failures++;
            $display("FAIL single_grant: got ready=%b sel=%0d expected ready=010 sel=5",
                     bus.req_ready, bus.sel);
        end
        after_edge();
        checks++;
        if (bus.rsp_valid !== 3'b010 || bus.rsp_data !== regs[5]) begin
            failures++;
            $display("FAIL single_rsp: got valid=%b data=%h expected valid=010 data=%h",
                     bus.rsp_valid, bus.rsp_data, regs[5]);
        end
        drive(3'b000, 3'b000, 3'd1, 3'd2, 3'd3);
        checks++;
        if (bus.req_ready !== 3'b000 || bus.sel !== 3'd5) begin
            failures++;
            $display("FAIL single_idle_sel: got ready=%b sel=%0d expected ready=000 sel=5",
                     bus.req_ready, bus.sel);
        end
        after_edge();
        checks++;
        if (bus.rsp_valid !== 3'b000 || bus.rsp_data !== regs[5]) begin
            failures++;
            $display("FAIL single_rsp_hold: got valid=%b data=%h expected valid=000 data=%h",
                     bus.rsp_valid, bus.rsp_data, regs[5]);
        end
    endtask

    task automatic test_reset_mid_lock();
        drive(3'b010, 3'b010, 3'd0, 3'd3, 3'd0);
        after_edge();
        @(negedge clk);
        bus.req_valid = 3'b000;
        bus.req_lock  = 3'b000;
        rst_n         = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 3'b000 || bus.sel !== 3'd0 ||
            bus.rsp_valid !== 3'b000 || bus.rsp_data !== 16'h0000) begin
            failures++;
            $display("FAIL midreset_outputs: got ready=%b sel=%0d valid=%b data=%h expected all zero",
                     bus.req_ready, bus.sel, bus.rsp_valid, bus.rsp_data);
        end
        checks++;
        if (dut.state !== ARB) begin
            failures++;
            $display("FAIL midreset_state: got %0d expected ARB", dut.state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'b100, 3'b000, 3'd0, 3'd0, 3'd6);
        checks++;
        if (bus.req_ready !== 3'b100 || bus.sel !== 3'd6) begin
            failures++;
            $display("FAIL midreset_grant: got ready=%b sel=%0d expected ready=100 sel=6",
                     bus.req_ready, bus.sel);
        end
        after_edge();
        checks++;
        if (bus.rsp_valid !== 3'b100 || bus.rsp_data !== regs[6]) begin
            failures++;
            $display("FAIL midreset_rsp: got valid=%b data=%h expected valid=100 data=%h",
                     bus.rsp_valid, bus.rsp_data, regs[6]);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 8; i++) begin
            regs[i] = 16'hC0DE ^ (16'(i) * 16'h1111);
        end
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_lock  = '0;
        bus.req_addr  = '0;
        #12;

        test_reset();
        test_round_robin();
        test_lock_dump();
        test_forced_release();
        test_single();
        test_reset_mid_lock();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_read_arbiter.md
# regfile_read_arbiter

Shares the single SR2 register-file read port (the 8:1 16-bit register select mux) between up to NUM_REQ requesters: datapath operand fetch, the debug/hex-display reader and the trap/interrupt save sequencer. It picks requesters round-robin, drives the mux select and returns the read data registered one cycle later. A lock mechanism lets one requester hold the port for back-to-back reads, for example a full R0–R7 dump.

## Interface
- NUM_REQ, 3: number of requesters, 2..8.
- DATA_W, 16: register width.
- ADDR_W, 3: register index width; the register file has 2**ADDR_W registers.
- LOCK_MAX, 15: consecutive idle owner cycles tolerated in LOCKED before forced release, 1..255.

- Clk  in  1  single clock; all state on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester read request.
- req_lock  in  NUM_REQ  sampled with req_valid; 1 means keep ownership after this read.
- req_addr  in  NUM_REQ*ADDR_W  requester i index at bits [i*ADDR_W +: ADDR_W].
- req_ready  out  NUM_REQ  one-hot or zero; request i accepted this cycle.
- sel  out  ADDR_W  select to the register-file read mux.
- rd_data  in  DATA_W  combinational mux output for the current sel.
- rsp_valid  out  NUM_REQ  one-hot or zero; response for requester i.
- rsp_data  out  DATA_W  read data accompanying rsp_valid.

## Operation
- Reset values:
  - Outputs: req_ready=0, sel=0, rsp_valid=0, rsp_data=0.
  - Internal state: state=ARB, rr_ptr=0, owner=0, idle_cnt=0, last_sel=0.
- States are ARB and LOCKED.
- ARB:
  - Grant the first requester with req_valid=1, searching from rr_ptr upward and wrapping at NUM_REQ-1 to 0.
  - On a grant to i: req_ready[i]=1 and rr_ptr←(i+1) mod NUM_REQ.
  - If req_lock[i]=1, go to LOCKED with owner←i and idle_cnt←0.
- LOCKED:
  - Only owner can be granted; all other req_ready bits are 0.
  - Owner grant with req_lock=1: stay in LOCKED, idle_cnt←0.
  - Owner grant with req_lock=0: this is the last beat; go to ARB.
  - Owner req_valid=0: idle_cnt←idle_cnt+1. When idle_cnt reaches LOCK_MAX, go to ARB on the next edge (forced release).
  - rr_ptr is not updated while LOCKED; on return to ARB it becomes (owner+1) mod NUM_REQ.
- sel:
  - On a grant, sel = req_addr of the granted requester, combinationally in the same cycle.
  - With no grant, sel = last_sel, the index of the most recent grant.
- Response: on each granted edge, rsp_data←rd_data and rsp_valid←onehot(granted). Otherwise rsp_valid←0 and rsp_data holds its value.
- There is no response backpressure. Each requester must consume rsp_valid when it arrives.
- Grants are never issued to a requester whose req_valid=0. req_ready never has more than one bit set.

## Timing
- Request to response latency is exactly 1 cycle. A grant in cycle T gives rsp_valid/rsp_data in T+1.
- One read per cycle is sustained, with back-to-back grants to the same or different requesters.
- Combinational paths: req_valid/req_addr → req_ready and sel. rd_data is registered only.
- Simultaneous requests from all NUM_REQ requesters each get exactly one grant within NUM_REQ cycles.
- Lock and a competing request on the same cycle: the lock grant wins, and the competitor waits until release.
- Reset_n asserted mid-operation clears all state immediately, including pending rsp_valid and LOCKED. No response is issued for a grant in the reset cycle.

## Structure
- Package lc3_rf_pkg holds:
  - arb_state_t enum {ARB, LOCKED};
  - LC3_REG_ADDR_W=3, LC3_DATA_W=16;
  - function onehot(idx).
- Sub-module rr_priority_pick: combinational; inputs are the request vector and the start pointer; outputs are valid, granted index and one-hot grant.
- Top-level sequential logic holds state, rr_ptr, owner, idle_cnt, last_sel and the response registers.

## Test plan
- Reset_n=0 mid-lock with NUM_REQ=3 → all outputs 0, state ARB; after release, req_valid=3'b100 → grant 2.
- req_valid=3'b111 held, addrs 1/4/7 → grants 0,1,2,0 on consecutive cycles; sel 1,4,7,1; rsp_data each cycle later equals register contents R1,R4,R7,R1.
- Requester 1 locks and reads R0..R7 (req_lock=1 on beats 0–6, 0 on beat 7) while req 0/2 are valid → eight consecutive grants to 1, then grant 2, because rr_ptr=2.
- Owner 1 locked, drops req_valid, LOCK_MAX=15 → 15 idle cycles later state returns to ARB; req 2 is granted on the following cycle.
- Single request req_valid=3'b010, addr 5, one cycle → req_ready=3'b010 same cycle, rsp_valid=3'b010 with R5 next cycle; afterwards sel stays 5 and rsp_valid=0.
